// File: rtl/ysyx_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_ifu -- instruction fetch unit with a credit-controlled prefetch buffer
//
// Issues word-aligned fetch requests to an in-order memory port and queues the
// returned instruction words, each tagged with its fetch address, for the
// decode stage. A request is only issued when a buffer slot is guaranteed for
// its response (buffered entries + outstanding requests < DEPTH), so the
// buffer can never overflow and responses never need back-pressure.
//
// A redirect flushes the buffer and restarts fetching at redirect_pc.
// Responses to requests issued before the redirect are still delivered by
// memory. They are counted in r_discard and dropped on arrival.
//
// Parameters
//   DEPTH     prefetch buffer entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mem_req_valid/ready/addr      fetch request channel (addr word aligned)
//   mem_rsp_valid/data            in-order response channel, always accepted
//   redirect, redirect_pc         flush and restart fetch at redirect_pc
//   inst_valid/ready, inst,       buffer head towards the consumer
//   inst_pc
//   misalign_err                  sticky flag: redirect to a non-word address
//
// Configuration
//   YSYX_IFU_ALIGN_CHECK_EN  when defined, a redirect whose redirect_pc[1:0]
//                            is non-zero sets misalign_err until reset.
//                            Otherwise misalign_err is tied low. In both
//                            builds the low two bits of redirect_pc are
//                            cleared before use.
// ---------------------------------------------------------------------------
module ysyx_ifu #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        misalign_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // Credit limit, widened so count + outstanding cannot overflow the compare.
   localparam logic [CW:0] CREDIT_LIM = (CW + 1)'(DEPTH);

   // Fetch address state
   logic [31:0]   r_fetch_pc;

   // Occupancy bookkeeping
   logic [CW-1:0] r_count;     // valid entries in the instruction buffer
   logic [CW-1:0] r_outst;     // requests accepted but not yet answered
   logic [CW-1:0] r_discard;   // outstanding responses that belong to a flushed stream

   // Instruction buffer (data + fetch address of each entry)
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [31:0]   r_data    [DEPTH];
   logic [31:0]   r_ipc     [DEPTH];

   // Request-order PC FIFO: one tag per outstanding request
   logic [PW-1:0] r_tag_wptr;
   logic [PW-1:0] r_tag_rptr;
   logic [31:0]   r_tag     [DEPTH];

   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic [CW:0]   w_inflight;
   logic [31:0]   w_redirect_pc;

   // Word-aligned restart address; the low bits are never used to fetch.
   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

   // Issue side: every accepted request reserves one buffer slot.
   assign w_inflight    = {1'b0, r_count} + {1'b0, r_outst};
   assign mem_req_valid = !rst && !redirect && (w_inflight < CREDIT_LIM);
   assign mem_req_addr  = r_fetch_pc;
   assign w_accept      = mem_req_valid && mem_req_ready;

   // Response side: stale responses are dropped, a response arriving together
   // with a redirect is also stale and is dropped.
   assign w_drop = (r_discard != '0);
   assign w_push = mem_rsp_valid && !redirect && !w_drop;

   // Consumer side: head of the buffer, no bypass from the response port.
   assign inst_valid = !rst && (r_count != '0);
   assign inst       = r_data[r_rptr];
   assign inst_pc    = r_ipc[r_rptr];
   assign w_pop      = inst_valid && inst_ready;

   // Fetch PC
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect) begin
         r_fetch_pc <= w_redirect_pc;
      end else if (w_accept) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   // Outstanding and discard counters. A redirect marks every request still
   // in flight as stale; a response arriving in that same cycle is already
   // accounted for by being dropped right away.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outst   <= '0;
         r_discard <= '0;
      end else begin
         r_outst <= r_outst + CW'(w_accept) - CW'(mem_rsp_valid);
         if (redirect) begin
            r_discard <= r_outst - CW'(mem_rsp_valid);
         end else if (mem_rsp_valid && w_drop) begin
            r_discard <= r_discard - CW'(1);
         end
      end
   end

   // Instruction buffer control. A pop in a redirect cycle is still a valid
   // handshake for the consumer; the flush then empties the buffer anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else if (redirect) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // PC tag FIFO pointers. Tags are written per accepted request and read per
   // response (dropped or not), so they stay aligned across redirects and are
   // only cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_wptr <= '0;
         r_tag_rptr <= '0;
      end else begin
         if (w_accept) begin
            r_tag_wptr <= r_tag_wptr + PW'(1);
         end
         if (mem_rsp_valid) begin
            r_tag_rptr <= r_tag_rptr + PW'(1);
         end
      end
   end

   // Storage arrays (no reset, qualified by the control state above)
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tag[r_tag_wptr] <= r_fetch_pc;
      end
      if (w_push) begin
         r_data[r_wptr] <= mem_rsp_data;
         r_ipc[r_wptr]  <= r_tag[r_tag_rptr];
      end
   end

`ifdef YSYX_IFU_ALIGN_CHECK_EN
   logic r_misalign;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
         r_misalign <= 1'b1;
      end
   end

   assign misalign_err = r_misalign;
`else
   // Low address bits are deliberately ignored in this build.
   logic [1:0] w_unused_pc_lo;
   assign w_unused_pc_lo = redirect_pc[1:0];
   assign misalign_err   = 1'b0;
`endif

endmodule
